// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage. It serves load/store requests from a word array
// with a fixed latency. Define DMEM_LAST_HIT_EN to add a one-entry last-access register.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re_mem,
  input  logic        we_mem,
  input  logic [15:0] addr,
  input  logic [15:0] sdata,
  input  logic        hlt,
  output logic [15:0] ldata,
  output logic        stall,
  output logic        done,
  output logic        err_both
);

  localparam int CW = $clog2(LATENCY + 1);
  // BUSY lasts LATENCY-1 cycles, so done rises exactly LATENCY cycles after accept.
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_idx;
  logic [15:0]     r_sdata;
  logic            r_wr;
  logic [15:0]     r_ldata;
  logic [15:0]     r_mem [DEPTH];

  logic            w_idle;
  logic            w_req;
  logic            w_hit;
  logic            w_accept;
  logic            w_complete;
  logic [AW-1:0]   w_acc_idx;
  logic [15:0]     w_acc_data;
  logic            w_acc_wr;
  logic [15:0]     w_rd_data;
  logic [15:0]     w_hit_data;

`ifdef DMEM_LAST_HIT_EN
  logic            r_lh_valid;
  logic [AW-1:0]   r_lh_tag;
  logic [15:0]     r_lh_data;

  assign w_hit      = w_idle & r_lh_valid & (r_lh_tag == addr[AW-1:0])
                    & re_mem & ~we_mem & ~hlt;
  assign w_hit_data = r_lh_data;
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  assign w_idle   = (r_state == S_IDLE);
  assign w_req    = (re_mem | we_mem) & ~hlt;
  assign w_accept = w_idle & w_req & ~w_hit;

  // With LATENCY==1 the access completes on the accept edge and uses the live inputs.
  assign w_complete = (w_accept & (LATENCY == 1))
                    | ((r_state == S_BUSY) & (r_cnt == '0));
  assign w_acc_idx  = w_idle ? addr[AW-1:0] : r_idx;
  assign w_acc_data = w_idle ? sdata        : r_sdata;
  assign w_acc_wr   = w_idle ? we_mem       : r_wr;
  assign w_rd_data  = r_mem[w_acc_idx];

  assign stall    = w_accept | (r_state == S_BUSY);
  assign done     = (r_state == S_DONE) | w_hit;
  assign err_both = w_accept & re_mem & we_mem;
  assign ldata    = w_hit ? w_hit_data : r_ldata;

  // The array is never cleared. Reset only blocks the completing write.
  always_ff @(posedge clk) begin
    if (rst_n && w_complete && w_acc_wr) begin
      r_mem[w_acc_idx] <= w_acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sdata   <= '0;
      r_wr      <= 1'b0;
      r_ldata   <= '0;
`ifdef DMEM_LAST_HIT_EN
      r_lh_valid <= 1'b0;
      r_lh_tag   <= '0;
      r_lh_data  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_ldata <= w_hit_data;
          end else if (w_accept) begin
            r_idx   <= addr[AW-1:0];
            r_sdata <= sdata;
            r_wr    <= we_mem;
            r_cnt   <= CNT_INIT;
            r_state <= (LATENCY == 1) ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_complete) begin
        if (!w_acc_wr) begin
          r_ldata <= w_rd_data;
        end
`ifdef DMEM_LAST_HIT_EN
        r_lh_valid <= 1'b1;
        r_lh_tag   <= w_acc_idx;
        r_lh_data  <= w_acc_wr ? w_acc_data : w_rd_data;
`endif
      end
    end
  end

  generate
    if (AW < 16) begin : g_addr_hi
      logic w_addr_hi_unused;
      assign w_addr_hi_unused = ^addr[15:AW];
    end
  endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. It runs directed scenarios and then random traffic.
// A transaction-level model checks every cycle.
module tb_dmem_responder;

  localparam int DEPTH = 256;
`ifdef DMEM_LAST_HIT_EN
  localparam int LAT    = 3;
  localparam bit HIT_EN = 1'b1;
`else
  localparam int LAT    = 2;
  localparam bit HIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re_mem = 1'b0;
  logic        we_mem = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] sdata = '0;
  logic        hlt = 1'b0;
  logic [15:0] ldata;
  logic        stall;
  logic        done;
  logic        err_both;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .re_mem(re_mem), .we_mem(we_mem), .addr(addr),
    .sdata(sdata), .hlt(hlt), .ldata(ldata), .stall(stall), .done(done),
    .err_both(err_both)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] fill_val(input int i);
    return 16'((i * 40503 + 7) ^ 16'hA5C3);
  endfunction

  // Transaction-level reference. A request accepted at offset 0 stalls for offsets 0..LAT-1.
  // Its effect lands at the end of offset LAT-1, and done is seen at offset LAT.
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_busy = 0;
  int          m_off = 0;
  bit          m_wr = 0;
  int          m_idx = 0;
  logic [15:0] m_d = '0;
  logic [15:0] m_ldata = '0;
  bit          m_ld_known = 1;
  bit          m_lv = 0;
  int          m_lt = 0;
  logic [15:0] m_ldd = '0;

  always @(negedge clk) begin
    int  idx_now;
    bit  req, hit, e_stall, e_done, e_err;
    logic [15:0] e_ld;
    bit  ld_chk;
    if (!rst_n) begin
      m_busy = 0; m_off = 0; m_ldata = '0; m_ld_known = 1; m_lv = 0;
    end else begin
      idx_now = int'(addr) % DEPTH;
      req = 0; hit = 0;
      if (!m_busy) begin
        req     = (re_mem || we_mem) && !hlt;
        hit     = HIT_EN && m_lv && (m_lt == idx_now) && re_mem && !we_mem && !hlt;
        e_stall = req && !hit;
        e_done  = hit;
        e_err   = req && !hit && re_mem && we_mem;
        e_ld    = hit ? m_ldd : m_ldata;
        ld_chk  = hit || m_ld_known;
      end else begin
        e_stall = (m_off <= LAT - 1);
        e_done  = (m_off == LAT);
        e_err   = 0;
        e_ld    = m_ldata;
        ld_chk  = m_ld_known;
      end
      chk("stall", stall, e_stall);
      chk("done", done, e_done);
      chk("err_both", err_both, e_err);
      if (ld_chk) chk("ldata", ldata, e_ld);

      if (!m_busy) begin
        if (hit) begin
          m_ldata = m_ldd; m_ld_known = 1;
        end else if (req) begin
          m_busy = 1; m_off = 0; m_wr = we_mem; m_idx = idx_now; m_d = sdata;
        end
      end
      if (m_busy) begin
        if (m_off == LAT - 1) begin
          if (m_wr) begin
            m_mem[m_idx] = m_d; m_known[m_idx] = 1; m_ldd = m_d;
          end else begin
            m_ldata = m_mem[m_idx]; m_ld_known = m_known[m_idx]; m_ldd = m_mem[m_idx];
          end
          m_lv = m_known[m_idx]; m_lt = m_idx;
        end
        if (m_off == LAT) m_busy = 0;
        else m_off++;
      end
    end
  end

  // Holds one request until done is seen. Returns the stall cycles and the ldata at done.
  task automatic do_op(input logic re, input logic we, input logic [15:0] a,
                       input logic [15:0] d, output int stalls,
                       output logic [15:0] ld, output bit errseen);
    bit got;
    stalls = 0; ld = '0; errseen = 0; got = 0;
    @(posedge clk); #1;
    re_mem = re; we_mem = we; addr = a; sdata = d; hlt = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (err_both) errseen = 1;
      if (done) begin got = 1; ld = ldata; end
    end
    if (!got) chk("op_timeout", 0, 1);
    @(posedge clk); #1;
    re_mem = 0; we_mem = 0;
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st, dones;
    logic [15:0] ld;
    bit eb;

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_ldata", ldata, 0);
    chk("rst_err", err_both, 0);

    for (int i = 0; i < DEPTH; i++) do_op(0, 1, 16'(i), fill_val(i), st, ld, eb);

    // Store followed by load.
    do_op(0, 1, 16'h0010, 16'hBEEF, st, ld, eb);
    chk("st_beef_stalls", st, LAT);
    do_op(1, 0, 16'h0010, 16'h0000, st, ld, eb);
    chk("ld_beef_stalls", st, HIT_EN ? 0 : LAT);
    chk("ld_beef_data", ld, 16'hBEEF);

    // The upper address bits alias onto the same word.
    do_op(0, 1, 16'h0105, 16'h1234, st, ld, eb);
    do_op(1, 0, 16'h0005, 16'h0000, st, ld, eb);
    chk("wrap_data", ld, 16'h1234);

    // Reset during BUSY aborts the store.
    @(posedge clk); #1;
    we_mem = 1; addr = 16'h0020; sdata = 16'hAAAA;
    @(posedge clk); #1;
    we_mem = 0; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rstmid_stall", stall, 0);
    chk("rstmid_ldata", ldata, 0);
    do_op(1, 0, 16'h0020, 16'h0000, st, ld, eb);
    chk("rstmid_keep", ld, fill_val(16'h20));

    // Both request lines high: the request is a store and ldata is unchanged.
    do_op(1, 1, 16'h0030, 16'h5555, st, ld, eb);
    chk("both_err", eb, 1);
    chk("both_ldata", ld, fill_val(16'h20));
    do_op(1, 0, 16'h0030, 16'h0000, st, ld, eb);
    chk("both_mem", ld, 16'h5555);

    // Halt in IDLE blocks acceptance. Halt after accept does not stop the access.
    @(posedge clk); #1;
    re_mem = 1; addr = 16'h0031; hlt = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hlt_idle_stall", stall, 0);
      chk("hlt_idle_done", done, 0);
    end
    @(posedge clk); #1 hlt = 0;
    @(posedge clk); #1 hlt = 1;
    dones = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("hlt_busy_dones", dones, 1);
    @(posedge clk); #1 re_mem = 0; hlt = 0;

`ifdef DMEM_LAST_HIT_EN
    do_op(0, 1, 16'h0041, 16'h0F0F, st, ld, eb);
    do_op(1, 0, 16'h0040, 16'h0000, st, ld, eb);
    chk("lh_miss_stalls", st, LAT);
    chk("lh_miss_data", ld, fill_val(16'h40));
    @(posedge clk); #1 re_mem = 1; addr = 16'h0040;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("lh_hit_stall", stall, 0);
      chk("lh_hit_done", done, 1);
      chk("lh_hit_data", ldata, fill_val(16'h40));
      @(posedge clk); #1;
    end
    re_mem = 0;
`endif

    // Random traffic. Inputs change every cycle, and there are occasional resets.
    for (int c = 0; c < 3000; c++) begin
      int r;
      @(posedge clk); #1;
      r = $urandom_range(0, 7);
      rst_n  = ($urandom_range(0, 299) != 0);
      re_mem = (r < 3);
      we_mem = (r >= 2 && r < 5);
      hlt    = ($urandom_range(0, 7) == 0);
      addr   = 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 255)) << 8);
      sdata  = 16'($urandom);
    end
    @(posedge clk); #1;
    rst_n = 1; re_mem = 0; we_mem = 0; hlt = 0;
    repeat (LAT + 4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
